jk_cmd_seq: RTL and testbench

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

---
 rtl/jk_cmd_seq.sv | 162 ++++++++++++++++
 tb/tb_jk_cmd_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: FIFO-buffered command sequencer that drives a downstream JK flip-flop
// and verifies its q. Define JK_CMD_SEQ_CHECK_EN to build the sticky mismatch flag (err).
module jk_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    output logic                     j,
    output logic                     k,
    input  logic                     q_in,
    output logic                     done,
    output logic                     err,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t        r_state;
    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_j;
    logic          r_k;
    logic          r_done;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_head;

    assign cmd_ready = (r_level != LVL_FULL);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == ST_IDLE) && (r_level != LVL_ZERO);
    assign w_head    = r_mem[r_rd_ptr];

    assign j     = r_j;
    assign k     = r_k;
    assign done  = r_done;
    assign level = r_level;

    // Command storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= LVL_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sequencer: IDLE pops and drives, DRIVE holds one cycle, CHECK retires with done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_pop) begin
                        r_j     <= w_head[1];
                        r_k     <= w_head[0];
                        r_state <= ST_DRIVE;
                    end else begin
                        r_j     <= 1'b0;
                        r_k     <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef JK_CMD_SEQ_CHECK_EN
    logic r_expected;
    logic r_err;

    function automatic logic exp_q(input logic [1:0] c, input logic q);
        case (c)
            2'b00:   exp_q = q;
            2'b01:   exp_q = 1'b0;
            2'b10:   exp_q = 1'b1;
            2'b11:   exp_q = ~q;
            default: exp_q = 1'b0;
        endcase
    endfunction

    // Expected q captured at pop; a new mismatch outranks a simultaneous err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_expected <= exp_q(w_head, q_in);
            end
            if ((r_state == ST_CHECK) && (q_in != r_expected)) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    logic w_unused_chk;
    assign w_unused_chk = err_clr ^ q_in;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Self-checking bench for jk_cmd_seq: a behavioural JK flip-flop closes the loop and a
// scoreboard queue holds the q value expected at each done pulse.
module tb_jk_cmd_seq;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef JK_CMD_SEQ_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic          cmd_ready;
    logic          j;
    logic          k;
    logic          q_in;
    logic          done;
    logic          err;
    logic          err_clr;
    logic [LW-1:0] level;

    logic ff_q;
    logic force_en;
    logic force_val;
    logic model_q;
    logic mon_exp;
    logic sbq[$];
    int   errors    = 0;
    int   checks    = 0;
    int   done_seen = 0;

    jk_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .j(j), .k(k), .q_in(q_in), .done(done), .err(err), .err_clr(err_clr), .level(level)
    );

    always #5 clk = ~clk;

    // Downstream JK flip-flop, deliberately never reset
    always @(posedge clk) begin
        case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
        endcase
    end

    assign q_in = force_en ? force_val : ff_q;

    // Each done pulse retires the oldest scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_seen++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: done pulse with no command outstanding");
            end else begin
                mon_exp = sbq.pop_front();
                if (ff_q !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_q: q=%b expected=%b", ff_q, mon_exp);
                end
            end
        end
    end

    task automatic sb_push(input logic [1:0] c);
        logic nq;
        case (c)
            2'b00:   nq = model_q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~model_q;
        endcase
        model_q = nq;
        sbq.push_back(nq);
    endtask

    task automatic push_cmd(input logic [1:0] c, output bit acc);
        cmd_valid = 1'b1;
        cmd       = c;
        acc       = (cmd_ready === 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (acc) sb_push(c);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || level !== 3'd0) begin
            errors++;
            $display("FAIL drain: outstanding=%0d level=%0d required 0/0", sbq.size(), level);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: no done pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; err_clr = 1'b0;
        force_en = 1'b0; force_val = 1'b0; model_q = 1'b0;
        #12;
        checks++;
        if ({j, k, done, err} !== 4'b0000 || level !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: jkde=%b%b%b%b level=%0d ready=%b required 0000/0/1",
                     j, k, done, err, level, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequence;
        bit acc;
        int d0 = done_seen;
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            push_cmd(seq[i], acc);
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL seq_accept: push %0d refused", i);
            end
        end
        wait_drain(40);
        checks++;
        if (done_seen - d0 != 4 || err !== 1'b0) begin
            errors++;
            $display("FAIL seq_done: done pulses=%0d err=%b required 4/0", done_seen - d0, err);
        end
    endtask

    task automatic test_stall;
        int acc = 0;
        logic [1:0] c;
        cmd_valid = 1'b1;
        for (int n = 0; n < 20 && cmd_ready === 1'b1; n++) begin
            c   = n[0] ? 2'b10 : 2'b01;
            cmd = c;
            @(posedge clk); #1;
            acc++;
            sb_push(c);
        end
        // 4 queued + 1 in flight + 1 already retired while filling
        checks++;
        if (acc != 6 || level !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_fill: pushes=%0d level=%0d ready=%b required 6/4/0",
                     acc, level, cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL stall_full_hold: level=%0d required 4", level);
        end
        cmd_valid = 1'b0;
        wait_drain(60);
    endtask

    task automatic test_err;
        bit acc;
        bit seen;
        push_cmd(2'b10, acc);
        force_val = 1'b0;
        force_en  = 1'b1;
        wait_done(10, seen);
        checks++;
        if (err !== CHECK_EN) begin
            errors++;
            $display("FAIL err_set: err=%b required %b", err, CHECK_EN);
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b required 0", err);
        end
        push_cmd(2'b10, acc);
        err_clr = 1'b1;
        wait_done(10, seen);
        checks++;
        if (err !== CHECK_EN) begin
            errors++;
            $display("FAIL err_clr_vs_set: err=%b required %b", err, CHECK_EN);
        end
        @(posedge clk); #1;
        err_clr  = 1'b0;
        force_en = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr2: err=%b required 0", err);
        end
        wait_drain(20);
    endtask

    task automatic test_reset_mid;
        bit acc;
        int d0;
        logic [1:0] seq [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        for (int i = 0; i < 5; i++) push_cmd(seq[i], acc);
        checks++;
        if (j !== 1'b1 || k !== 1'b0 || level !== 3'd3) begin
            errors++;
            $display("FAIL pre_rst_drive: j=%b k=%b level=%0d required 1/0/3", j, k, level);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (j !== 1'b0 || k !== 1'b0 || level !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: j=%b k=%b level=%0d done=%b required 0/0/0/0",
                     j, k, level, done);
        end
        sbq.delete();
        model_q = 1'b0;
        d0 = done_seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_cmd(2'b01, acc);
        checks++;
        if (!acc || level !== 3'd1 || done_seen != d0) begin
            errors++;
            $display("FAIL rst_first_push: acc=%0d level=%0d dones=%0d required 1/1/0",
                     acc, level, done_seen - d0);
        end
        wait_drain(20);
    endtask

    task automatic test_same_edge;
        bit acc;
        push_cmd(2'b10, acc);
        push_cmd(2'b01, acc);
        push_cmd(2'b11, acc);
        @(posedge clk); #1;
        checks++;
        if (level !== 3'd2) begin
            errors++;
            $display("FAIL same_edge_pre: level=%0d required 2", level);
        end
        push_cmd(2'b01, acc);
        checks++;
        if (!acc || level !== 3'd2) begin
            errors++;
            $display("FAIL same_edge_level: acc=%0d level=%0d required 1/2", acc, level);
        end
        wait_drain(40);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_err();
        test_reset_mid();
        test_same_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
